// File: rtl/credit_hit_detector.sv
// credit_hit_detector
// Producer side of the ball/credit collision interface. Turns per-pixel
// ball/credit overlap into one registered hit pulse per distinct contact.
// A frame-based contact/lockout state machine keeps a resting or grazing
// ball from generating repeated hits, and a saturating counter feeds the
// score logic.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | armed; the first overlap pixel produces a hit
// CONTACT | ball touching a credit; waits for a whole frame with no overlap
// LOCKOUT | counting contact-free frames down before re-arming
module credit_hit_detector #(
   parameter int NUM_CREDITS    = 4,
   parameter int LOCKOUT_FRAMES = 8,
   parameter int COUNT_WIDTH    = 8
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic                   startOfFrame,
   input  logic                   enable,
   input  logic                   drawBall,
   input  logic                   drawCredit,
   input  logic [3:0]             creditIndex,
   output logic                   collisionBallCredit,
   output logic [3:0]             hitIndex,
   output logic [COUNT_WIDTH-1:0] hitCount
);

   // Counter must hold LOCKOUT_FRAMES; keep at least one bit when it is zero.
   localparam int LOCK_W = (LOCKOUT_FRAMES < 1) ? 1 : $clog2(LOCKOUT_FRAMES + 1);
   localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(LOCKOUT_FRAMES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONTACT = 2'd1,
      LOCKOUT = 2'd2
   } state_t;

   state_t            state, stateNext;
   logic [LOCK_W-1:0] lockCnt, lockNext;
   logic              overlapSeen, seenNext;
   logic              hitNext;
   logic              overlap;

   assign overlap = enable && drawBall && drawCredit && (int'(creditIndex) < NUM_CREDITS);

   // Next-state, lockout down-counter and frame-level contact flag.
   always_comb begin
      stateNext = state;
      lockNext  = lockCnt;
      hitNext   = 1'b0;
      // On a frame start the old flag is consumed below, then reloaded with
      // this pixel's overlap because that pixel belongs to the new frame.
      seenNext  = startOfFrame ? overlap : (overlapSeen | overlap);

      case (state)
         IDLE: begin
            if (overlap) begin
               hitNext   = 1'b1;
               stateNext = CONTACT;
            end
         end
         CONTACT: begin
            if (startOfFrame && !overlapSeen) begin
               if (LOCKOUT_FRAMES == 0) begin
                  stateNext = IDLE;
               end else begin
                  stateNext = LOCKOUT;
                  lockNext  = LOCK_INIT;
               end
            end
         end
         LOCKOUT: begin
            if (startOfFrame) begin
               if (overlapSeen) begin
                  stateNext = CONTACT;
                  lockNext  = '0;
               end else if (lockCnt <= LOCK_W'(1)) begin
                  stateNext = IDLE;
                  lockNext  = '0;
               end else begin
                  lockNext = lockCnt - LOCK_W'(1);
               end
            end
         end
         default: begin
            stateNext = IDLE;
            lockNext  = '0;
         end
      endcase

      // Game stopped: drop any contact history and stay disarmed of pulses.
      if (!enable) begin
         stateNext = IDLE;
         lockNext  = '0;
         seenNext  = 1'b0;
         hitNext   = 1'b0;
      end
   end

   // State, flag and registered outputs; hit index/count change with the pulse.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state               <= IDLE;
         lockCnt             <= '0;
         overlapSeen         <= 1'b0;
         collisionBallCredit <= 1'b0;
         hitIndex            <= '0;
         hitCount            <= '0;
      end else begin
         state               <= stateNext;
         lockCnt             <= lockNext;
         overlapSeen         <= seenNext;
         collisionBallCredit <= hitNext;
         if (hitNext) begin
            hitIndex <= creditIndex;
            if (hitCount != '1) begin
               hitCount <= hitCount + COUNT_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_credit_hit_detector.sv
// Bench for credit_hit_detector: directed scenarios plus randomized frames,
// all checked cycle by cycle against a frame-counting reference model.
module tb_credit_hit_detector;

   localparam int NC = 4;
   localparam int LF = 8;
   localparam int CW = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          resetN = 1'b0;
   logic          startOfFrame = 1'b0;
   logic          enable = 1'b0;
   logic          drawBall = 1'b0;
   logic          drawCredit = 1'b0;
   logic [3:0]    creditIndex = '0;
   logic          collisionBallCredit;
   logic [3:0]    hitIndex;
   logic [CW-1:0] hitCount;

   int checks = 0;
   int failures = 0;
   int dutPulses = 0;

   // Reference model: a hit is accepted while armed. After a hit the model
   // re-arms only once 1+LF consecutive completed frames had no overlap.
   bit armed = 1'b1;
   int quiet = 0;
   bit frameHad = 1'b0;
   bit expPulse = 1'b0;
   int expIdx = 0;
   int expCnt = 0;

   credit_hit_detector #(
      .NUM_CREDITS   (NC),
      .LOCKOUT_FRAMES(LF),
      .COUNT_WIDTH   (CW)
   ) dut (
      .clk                (clk),
      .resetN             (resetN),
      .startOfFrame       (startOfFrame),
      .enable             (enable),
      .drawBall           (drawBall),
      .drawCredit         (drawCredit),
      .creditIndex        (creditIndex),
      .collisionBallCredit(collisionBallCredit),
      .hitIndex           (hitIndex),
      .hitCount           (hitCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive on the falling edge, update the model at the rising
   // edge, compare shortly after.
   task automatic step(input bit rst, input bit sof, input bit en, input bit ball,
                       input bit cred, input int idx);
      bit ov;
      bit hit;
      @(negedge clk);
      resetN       = !rst;
      startOfFrame = sof;
      enable       = en;
      drawBall     = ball;
      drawCredit   = cred;
      creditIndex  = 4'(idx);
      @(posedge clk);
      ov  = en && ball && cred && (idx < NC);
      hit = 1'b0;
      if (rst) begin
         armed = 1'b1; quiet = 0; frameHad = 1'b0;
         expPulse = 1'b0; expIdx = 0; expCnt = 0;
      end else if (!en) begin
         armed = 1'b1; quiet = 0; frameHad = 1'b0;
         expPulse = 1'b0;
      end else begin
         hit = armed && ov;
         if (sof) begin
            if (frameHad) quiet = 0;
            else quiet++;
            if (quiet > LF) armed = 1'b1;
         end
         if (hit) begin
            armed  = 1'b0;
            quiet  = 0;
            expIdx = idx;
            if (expCnt < CMAX) expCnt++;
         end
         frameHad = sof ? ov : (frameHad | ov);
         expPulse = hit;
      end
      #1;
      if (collisionBallCredit === 1'b1) dutPulses++;
      check("pulse", 32'(collisionBallCredit), 32'(expPulse));
      check("hitIndex", 32'(hitIndex), 32'(expIdx));
      check("hitCount", 32'(hitCount), 32'(expCnt));
   endtask

   task automatic run_frame(input int len, input int ovStart, input int ovLen,
                            input int idx, input bit en);
      for (int p = 0; p < len; p++) begin
         bit ov;
         ov = (p >= ovStart) && (p < ovStart + ovLen);
         step(1'b0, p == 0, en, ov, ov, idx);
      end
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      dutPulses = 0;
   endtask

   initial begin
      // Single pixel hit on credit 2, then quiet frames.
      do_reset();
      check("rst_hitCount", 32'(hitCount), 32'd0);
      check("rst_hitIndex", 32'(hitIndex), 32'd0);
      run_frame(20, 5, 1, 2, 1'b1);
      for (int f = 0; f < 3; f++) run_frame(20, -1, 0, 0, 1'b1);
      check("t1_pulses", 32'(dutPulses), 32'd1);
      check("t1_idx", 32'(hitIndex), 32'd2);
      check("t1_cnt", 32'(hitCount), 32'd1);

      // Resting ball: 50 overlap pixels per frame for 5 frames.
      do_reset();
      for (int f = 0; f < 5; f++) run_frame(60, 5, 50, 1, 1'b1);
      check("t2_pulses", 32'(dutPulses), 32'd1);
      check("t2_cnt", 32'(hitCount), 32'd1);

      // Re-hit after full lockout: contact frame 0, quiet 1-9, contact 10.
      do_reset();
      run_frame(8, 2, 1, 0, 1'b1);
      for (int f = 1; f <= 9; f++) run_frame(8, -1, 0, 0, 1'b1);
      run_frame(8, 3, 1, 3, 1'b1);
      check("t3_pulses", 32'(dutPulses), 32'd2);
      check("t3_cnt", 32'(hitCount), 32'd2);
      check("t3_idx", 32'(hitIndex), 32'd3);

      // Contact inside lockout (frame 5) returns to contact: no re-hit at 11.
      do_reset();
      run_frame(8, 2, 1, 0, 1'b1);
      for (int f = 1; f <= 11; f++) run_frame(8, (f == 5 || f == 11) ? 2 : -1, 1, 1, 1'b1);
      check("t3b_pulses", 32'(dutPulses), 32'd1);

      // Overlap pixel coincident with startOfFrame.
      do_reset();
      run_frame(10, 0, 1, 3, 1'b1);
      check("t4_pulses", 32'(dutPulses), 32'd1);
      check("t4_idx", 32'(hitIndex), 32'd3);

      // Out-of-range credit index, then overlap while disabled, then enabled.
      do_reset();
      run_frame(10, 2, 3, 7, 1'b1);
      check("t5_badidx", 32'(dutPulses), 32'd0);
      run_frame(10, 2, 3, 1, 1'b0);
      check("t5_disabled", 32'(dutPulses), 32'd0);
      run_frame(10, 2, 1, 1, 1'b1);
      check("t5_reenable", 32'(dutPulses), 32'd1);
      check("t5_idx", 32'(hitIndex), 32'd1);

      // Saturation: 256 well-separated hits.
      do_reset();
      for (int h = 0; h < 256; h++) begin
         run_frame(4, 1, 1, h % NC, 1'b1);
         for (int f = 0; f < 9; f++) run_frame(4, -1, 0, 0, 1'b1);
      end
      check("t6_pulses", 32'(dutPulses), 32'd256);
      check("t6_sat", 32'(hitCount), 32'd255);

      // Reset during lockout, then immediate overlap pulses.
      do_reset();
      run_frame(8, 2, 1, 2, 1'b1);
      for (int f = 0; f < 3; f++) run_frame(8, -1, 0, 0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      check("t7_rst_cnt", 32'(hitCount), 32'd0);
      check("t7_rst_pulse", 32'(collisionBallCredit), 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1);
      check("t7_after_rst", 32'(collisionBallCredit), 32'd1);
      check("t7_cnt", 32'(hitCount), 32'd1);

      // Randomized frames with occasional missing frame starts, enable drops
      // and resets.
      do_reset();
      for (int f = 0; f < 2000; f++) begin
         int len;
         bit hasOv;
         len   = $urandom_range(2, 12);
         hasOv = ($urandom_range(0, 99) < 25);
         for (int p = 0; p < len; p++) begin
            bit sof, en, rst, ball, cred;
            sof  = (p == 0) && ($urandom_range(0, 9) != 0);
            en   = ($urandom_range(0, 199) != 0);
            rst  = ($urandom_range(0, 999) == 0);
            ball = hasOv && ($urandom_range(0, 2) == 0);
            cred = hasOv && ($urandom_range(0, 1) == 0);
            step(rst, sof, en, ball, cred, $urandom_range(0, 5));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
